// File: rtl/pc_next_unit_if.sv
// Handshake/bus bundle between decode/ALU, the PC unit and instruction fetch.
// The master drives instruction context. The slave (the PC unit) returns PC and status.
interface pc_next_unit_if #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 io_valid;
  logic                 io_stall;
  logic [31:0]          io_instruction;
  logic [XLEN-1:0]      io_rs1_data;
  logic                 io_branch_taken;
  logic [2:0]           io_pc_next_type;
  logic [XLEN-1:0]      io_trap_vector;

  logic [XLEN-1:0]      io_pc;
  logic [XLEN-1:0]      io_pc_next;
  logic                 io_is_unknown_instruction;
  logic                 io_halted;
  logic                 io_fault;
  logic [XLEN-1:0]      io_fault_pc;
  logic [1:0]           io_fault_cause;
  logic [CNT_WIDTH-1:0] io_retired;

  modport master (
    output io_valid, io_stall, io_instruction, io_rs1_data, io_branch_taken,
           io_pc_next_type, io_trap_vector,
    input  io_pc, io_pc_next, io_is_unknown_instruction, io_halted, io_fault,
           io_fault_pc, io_fault_cause, io_retired
  );

  modport slave (
    input  io_valid, io_stall, io_instruction, io_rs1_data, io_branch_taken,
           io_pc_next_type, io_trap_vector,
    output io_pc, io_pc_next, io_is_unknown_instruction, io_halted, io_fault,
           io_fault_pc, io_fault_cause, io_retired
  );
endinterface

// File: rtl/pc_next_unit.sv
// Architectural PC register and next-PC selection for the single-cycle RV core,
// with stall gating, misaligned-target faults, trap redirect, halt and retire count.
module pc_next_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h80000000),
  parameter int              CNT_WIDTH    = 32
) (
  input  logic          clock,
  input  logic          reset,
  pc_next_unit_if.slave bus
);

  typedef enum logic [2:0] {
    T_SEQ     = 3'd0,
    T_JAL     = 3'd1,
    T_JALR    = 3'd2,
    T_UNKNOWN = 3'd3,
    T_HALT    = 3'd4,
    T_BRANCH  = 3'd5,
    T_TRAP    = 3'd6,
    T_RSVD    = 3'd7
  } pc_type_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FAULT  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_UNKNOWN = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

  function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] ins);
    return {{(XLEN-12){ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] ins);
    return {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] ins);
    return {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  state_e               state_q,    state_d;
  logic [XLEN-1:0]      pc_q,       pc_d;
  logic [XLEN-1:0]      fault_pc_q, fault_pc_d;
  logic [1:0]           cause_q,    cause_d;
  logic [CNT_WIDTH-1:0] retired_q,  retired_d;

  pc_type_e               pc_type;
  logic signed [XLEN-1:0] off_i;
  logic signed [XLEN-1:0] off_j;
  logic signed [XLEN-1:0] off_b;
  logic [XLEN-1:0]        pc_plus4;
  logic [XLEN-1:0]        jal_tgt;
  logic [XLEN-1:0]        jalr_tgt;
  logic [XLEN-1:0]        br_tgt;
  logic [XLEN-1:0]        cand;
  logic                   misaligned;
  logic                   unknown;
  logic                   accept;

  assign pc_type  = pc_type_e'(bus.io_pc_next_type);
  assign off_i    = imm_i(bus.io_instruction);
  assign off_j    = imm_j(bus.io_instruction);
  assign off_b    = imm_b(bus.io_instruction);

  // All target sums wrap modulo 2^XLEN; offsets are two's-complement so plain adds suffice.
  assign pc_plus4 = pc_q + XLEN'(4);
  assign jal_tgt  = pc_q + $unsigned(off_j);
  assign jalr_tgt = (bus.io_rs1_data + $unsigned(off_i)) & ~XLEN'(1);
  assign br_tgt   = pc_q + $unsigned(off_b);

  assign unknown  = (pc_type == T_UNKNOWN) || (pc_type == T_RSVD);
  assign accept   = (state_q == ST_RUN) && bus.io_valid && !bus.io_stall;

  // Candidate is shown every cycle regardless of state, valid or stall.
  always_comb begin
    cand       = pc_q;
    misaligned = 1'b0;
    case (pc_type)
      T_SEQ:    cand = pc_plus4;
      T_JAL: begin
        cand       = jal_tgt;
        misaligned = jal_tgt[1];
      end
      T_JALR: begin
        cand       = jalr_tgt;
        misaligned = jalr_tgt[1];
      end
      T_BRANCH: begin
        cand       = bus.io_branch_taken ? br_tgt : pc_plus4;
        misaligned = bus.io_branch_taken && br_tgt[1];
      end
      T_TRAP:   cand = bus.io_trap_vector;
      default:  cand = pc_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    cause_d    = cause_q;
    retired_d  = retired_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (unknown) begin
            fault_pc_d = pc_q;
            cause_d    = CAUSE_UNKNOWN;
            state_d    = ST_FAULT;
          end else if (misaligned) begin
            fault_pc_d = pc_q;
            cause_d    = CAUSE_MISALIGN;
            state_d    = ST_FAULT;
          end else if (pc_type == T_HALT) begin
            retired_d  = retired_q + CNT_WIDTH'(1);
            state_d    = ST_HALTED;
          end else begin
            pc_d       = cand;
            retired_d  = retired_q + CNT_WIDTH'(1);
          end
        end
      end
      // Redirect takes exactly one cycle; stall and valid are deliberately ignored here.
      ST_FAULT: begin
        pc_d    = bus.io_trap_vector;
        state_d = ST_RUN;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VECTOR;
      fault_pc_q <= '0;
      cause_q    <= CAUSE_NONE;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      cause_q    <= cause_d;
      retired_q  <= retired_d;
    end
  end

  assign bus.io_pc                     = pc_q;
  assign bus.io_pc_next                = cand;
  assign bus.io_is_unknown_instruction = unknown;
  assign bus.io_halted                 = (state_q == ST_HALTED);
  assign bus.io_fault                  = (state_q == ST_FAULT);
  assign bus.io_fault_pc               = fault_pc_q;
  assign bus.io_fault_cause            = cause_q;
  assign bus.io_retired                = retired_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: each scenario pushes the expected architectural
// state when it drives a cycle and pops/compares it once that cycle has been clocked.
module tb_pc_next_unit;
  localparam int XLEN = 32;
  localparam int CW   = 4;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] JAL8 = 32'h0080006F;
  localparam logic [31:0] BEQM = 32'hFE000EE3;
  localparam logic [31:0] JALR = 32'h00008067;
  localparam logic [31:0] TV1  = 32'h80000100;
  localparam logic [31:0] TV2  = 32'h80000200;

  typedef struct packed {
    logic [31:0]   pc;
    logic [CW-1:0] ret;
    logic          halted;
    logic          fault;
    logic [1:0]    cause;
    logic [31:0]   fpc;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pc_next_unit_if #(.XLEN(XLEN), .CNT_WIDTH(CW)) bus ();

  pc_next_unit #(
    .XLEN(XLEN), .RESET_VECTOR(32'h80000000), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam obs_t RST_OBS = '{32'h80000000, 4'd0, 1'b0, 1'b0, 2'd0, 32'd0};

  function automatic obs_t snap();
    return {bus.io_pc, bus.io_retired, bus.io_halted, bus.io_fault,
            bus.io_fault_cause, bus.io_fault_pc};
  endfunction

  task automatic apply(input logic rst, input logic v, input logic s,
                       input logic [2:0] t, input logic [31:0] ins,
                       input logic [31:0] rs1, input logic tk, input logic [31:0] tv);
    reset               = rst;
    bus.io_valid        = v;
    bus.io_stall        = s;
    bus.io_pc_next_type = t;
    bus.io_instruction  = ins;
    bus.io_rs1_data     = rs1;
    bus.io_branch_taken = tk;
    bus.io_trap_vector  = tv;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, e;
    apply(1, 0, 0, 3'd0, NOP, 0, 0, TV1);
    exp_q.push_back(RST_OBS);
    tick(); tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL reset: got %h expected %h", got, e); end
    apply(0, 0, 0, 3'd0, NOP, 0, 0, TV1);
    exp_q.push_back(RST_OBS);
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL no_accept: got %h expected %h", got, e); end
    for (int k = 1; k <= 3; k++) begin
      apply(0, 1, 0, 3'd0, NOP, 0, 0, TV1);
      exp_q.push_back(obs_t'{32'h80000000 + 32'(4*k), CW'(k), 1'b0, 1'b0, 2'd0, 32'd0});
      tick();
      got = snap(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL seq%0d: got %h expected %h", k, got, e); end
    end
  endtask

  task automatic test_jal_stall();
    obs_t got, e;
    apply(1, 0, 0, 3'd0, NOP, 0, 0, TV1);
    exp_q.push_back(RST_OBS);
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL jal_rst: got %h expected %h", got, e); end
    for (int k = 0; k < 2; k++) begin
      apply(0, 1, 1, 3'd1, JAL8, 0, 0, TV1);
      #1;
      n_tests++;
      if (bus.io_pc_next !== 32'h80000008) begin
        n_fail++; $display("FAIL jal_next: got %h expected %h", bus.io_pc_next, 32'h80000008);
      end
      exp_q.push_back(RST_OBS);
      tick();
      got = snap(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL jal_stall%0d: got %h expected %h", k, got, e); end
    end
    apply(0, 1, 0, 3'd1, JAL8, 0, 0, TV1);
    exp_q.push_back(obs_t'{32'h80000008, 4'd1, 1'b0, 1'b0, 2'd0, 32'd0});
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL jal_go: got %h expected %h", got, e); end
  endtask

  task automatic test_branch();
    obs_t got, e;
    for (int k = 1; k <= 2; k++) begin
      apply(0, 1, 0, 3'd0, NOP, 0, 0, TV1);
      exp_q.push_back(obs_t'{32'h80000008 + 32'(4*k), CW'(1+k), 1'b0, 1'b0, 2'd0, 32'd0});
      tick();
      got = snap(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL br_pre%0d: got %h expected %h", k, got, e); end
    end
    apply(0, 1, 0, 3'd5, BEQM, 0, 1, TV1);
    #1;
    n_tests++;
    if (bus.io_pc_next !== 32'h8000000C) begin
      n_fail++; $display("FAIL br_taken_next: got %h expected %h", bus.io_pc_next, 32'h8000000C);
    end
    exp_q.push_back(obs_t'{32'h8000000C, 4'd4, 1'b0, 1'b0, 2'd0, 32'd0});
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL br_taken: got %h expected %h", got, e); end
    apply(0, 1, 0, 3'd0, NOP, 0, 0, TV1);
    exp_q.push_back(obs_t'{32'h80000010, 4'd5, 1'b0, 1'b0, 2'd0, 32'd0});
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL br_mid: got %h expected %h", got, e); end
    apply(0, 1, 0, 3'd5, BEQM, 0, 0, TV1);
    #1;
    n_tests++;
    if (bus.io_pc_next !== 32'h80000014) begin
      n_fail++; $display("FAIL br_nt_next: got %h expected %h", bus.io_pc_next, 32'h80000014);
    end
    exp_q.push_back(obs_t'{32'h80000014, 4'd6, 1'b0, 1'b0, 2'd0, 32'd0});
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL br_not_taken: got %h expected %h", got, e); end
  endtask

  task automatic test_jalr_misaligned();
    obs_t got, e;
    for (int k = 1; k <= 3; k++) begin
      apply(0, 1, 0, 3'd0, NOP, 0, 0, TV1);
      exp_q.push_back(obs_t'{32'h80000014 + 32'(4*k), CW'(6+k), 1'b0, 1'b0, 2'd0, 32'd0});
      tick();
      got = snap(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL jalr_pre%0d: got %h expected %h", k, got, e); end
    end
    apply(0, 1, 0, 3'd2, JALR, 32'h80001003, 0, TV1);
    #1;
    n_tests++;
    if (bus.io_pc_next !== 32'h80001002) begin
      n_fail++; $display("FAIL jalr_next: got %h expected %h", bus.io_pc_next, 32'h80001002);
    end
    exp_q.push_back(obs_t'{32'h80000020, 4'd9, 1'b0, 1'b1, 2'd2, 32'h80000020});
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL jalr_fault: got %h expected %h", got, e); end
    // Fault redirect must ignore stall and valid.
    apply(0, 1, 1, 3'd0, NOP, 0, 0, TV1);
    exp_q.push_back(obs_t'{TV1, 4'd9, 1'b0, 1'b0, 2'd2, 32'h80000020});
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL jalr_trap: got %h expected %h", got, e); end
  endtask

  task automatic test_unknown_wrap();
    obs_t got, e;
    apply(1, 0, 0, 3'd0, NOP, 0, 0, TV2);
    exp_q.push_back(RST_OBS);
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL unk_rst: got %h expected %h", got, e); end
    for (int k = 1; k <= 15; k++) begin
      apply(0, 1, 0, 3'd0, NOP, 0, 0, TV2);
      exp_q.push_back(obs_t'{32'h80000000 + 32'(4*k), CW'(k), 1'b0, 1'b0, 2'd0, 32'd0});
      tick();
      got = snap(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL unk_seq%0d: got %h expected %h", k, got, e); end
    end
    apply(0, 1, 0, 3'd7, 32'hFFFFFFFF, 0, 0, TV2);
    #1;
    n_tests++;
    if (bus.io_is_unknown_instruction !== 1'b1) begin
      n_fail++; $display("FAIL unk_flag: got %b expected 1", bus.io_is_unknown_instruction);
    end
    exp_q.push_back(obs_t'{32'h8000003C, 4'd15, 1'b0, 1'b1, 2'd1, 32'h8000003C});
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL unk_fault: got %h expected %h", got, e); end
    apply(0, 0, 0, 3'd0, NOP, 0, 0, TV2);
    exp_q.push_back(obs_t'{TV2, 4'd15, 1'b0, 1'b0, 2'd1, 32'h8000003C});
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL unk_trap: got %h expected %h", got, e); end
    apply(0, 1, 0, 3'd0, NOP, 0, 0, TV2);
    exp_q.push_back(obs_t'{TV2 + 32'd4, 4'd0, 1'b0, 1'b0, 2'd1, 32'h8000003C});
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL unk_wrap: got %h expected %h", got, e); end
  endtask

  task automatic test_halt_reset();
    obs_t got, e;
    apply(0, 1, 0, 3'd4, NOP, 0, 0, TV1);
    exp_q.push_back(obs_t'{32'h80000204, 4'd1, 1'b1, 1'b0, 2'd1, 32'h8000003C});
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL halt: got %h expected %h", got, e); end
    for (int k = 0; k < 5; k++) begin
      apply(0, 1, 0, 3'd1, JAL8, 0, 0, TV1);
      exp_q.push_back(obs_t'{32'h80000204, 4'd1, 1'b1, 1'b0, 2'd1, 32'h8000003C});
      tick();
      got = snap(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL halt_hold%0d: got %h expected %h", k, got, e); end
    end
    n_tests++;
    if (bus.io_pc_next !== 32'h8000020C) begin
      n_fail++; $display("FAIL halt_next: got %h expected %h", bus.io_pc_next, 32'h8000020C);
    end
    apply(1, 1, 0, 3'd1, JAL8, 0, 0, TV1);
    exp_q.push_back(RST_OBS);
    tick();
    got = snap(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL halt_rst: got %h expected %h", got, e); end
    apply(0, 0, 0, 3'd0, NOP, 0, 0, TV1);
  endtask

  initial begin
    apply(1, 0, 0, 3'd0, NOP, 0, 0, TV1);
    test_reset();
    test_jal_stall();
    test_branch();
    test_jalr_misaligned();
    test_unknown_wrap();
    test_halt_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised next-generation program-counter unit for the single-cycle RV core.
- Owns the architectural PC register and computes the next PC for sequential, JAL, JALR, conditional branch, trap and halt flows.
- Adds stall gating, misaligned-target detection, a one-cycle fault redirect to a trap vector, a halt state and a retired-instruction counter.
- Sits between decode/ALU (type, operands, branch outcome) and instruction fetch (io_pc).

Parameters:
- XLEN, 32, datapath and PC width (≥32); immediates sign-extended to XLEN.
- RESET_VECTOR, 32'h80000000, PC value loaded on reset.
- CNT_WIDTH, 32, width of retired-instruction counter.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- io_valid  in  1  instruction at io_pc is valid this cycle
- io_stall  in  1  hold PC and state this cycle
- io_instruction  in  32  current instruction word
- io_rs1_data  in  XLEN  rs1 operand for JALR
- io_branch_taken  in  1  branch comparison result from ALU
- io_pc_next_type  in  3  0 SEQ, 1 JAL, 2 JALR, 3 UNKNOWN, 4 HALT, 5 BRANCH, 6 TRAP, 7 reserved (treated as UNKNOWN)
- io_trap_vector  in  XLEN  trap target (mtvec)
- io_pc  out  XLEN  registered current PC
- io_pc_next  out  XLEN  combinational candidate next PC
- io_is_unknown_instruction  out  1  combinational: type 3 or 7
- io_halted  out  1  state == HALTED
- io_fault  out  1  state == FAULT
- io_fault_pc  out  XLEN  PC of last faulting instruction
- io_fault_cause  out  2  0 none, 1 unknown instr, 2 misaligned target
- io_retired  out  CNT_WIDTH  count of accepted instructions

Behaviour:
- Reset values: io_pc=RESET_VECTOR; state RUN; io_fault_pc=0; io_fault_cause=0; io_retired=0. Reset overrides every other input in the same cycle, including mid-HALT and mid-FAULT.
- Candidate targets, all sums mod 2^XLEN:
  - SEQ: pc+4
  - JAL: pc + sext({i[31],i[19:12],i[20],i[30:21],0})
  - JALR: (rs1 + sext(i[31:20])) & ~1
  - BRANCH: taken ? pc + sext({i[31],i[7],i[30:25],i[11:8],0}) : pc+4
  - TRAP: io_trap_vector
  - HALT and UNKNOWN: pc
- io_pc_next shows the candidate every cycle, independent of state, valid and stall.
- Misaligned: candidate[1] != 0 for JAL, JALR or taken BRANCH. The TRAP vector is not checked.
- accept = state==RUN && io_valid && !io_stall.
- State machine:
  - RUN, no accept: PC, state and counter hold.
  - RUN, accept, UNKNOWN: PC holds; io_fault_pc<=pc; cause<=1; go to FAULT.
  - RUN, accept, misaligned: PC holds; io_fault_pc<=pc; cause<=2; go to FAULT.
  - RUN, accept, HALT: PC holds; retired+1; go to HALTED.
  - RUN, accept, otherwise: pc<=candidate; retired+1; stay in RUN.
  - FAULT lasts exactly one cycle, whatever io_stall and io_valid are: pc<=io_trap_vector (sampled that cycle); back to RUN. io_fault_cause stays until the next fault or reset.
  - HALTED is sticky until reset; all inputs ignored.
- Latency: io_pc changes the cycle after accept. A fault costs 2 cycles to reach the trap vector.
- Counter: increments only on accepted, non-faulting instructions; wraps from all-ones to 0. Faulting instructions are not counted.
- Stall held across multiple cycles: PC, state and counter are frozen. io_pc_next keeps tracking the inputs.

Test Plan:
- Reset: hold reset 2 cycles, then release -> io_pc=0x80000000, io_retired=0, io_halted=0, io_fault=0. Then 3 accepted SEQ -> io_pc=0x8000000C, io_retired=3.
- JAL and stall: pc=0x80000000, instr 0x0080006F, type 1, stall=1 for 2 cycles -> io_pc stays 0x80000000 and io_pc_next=0x80000008. Release stall -> io_pc=0x80000008 next cycle, retired+1.
- BRANCH backward: pc=0x80000010, instr 0xFE000EE3 (beq -4), taken=1 -> io_pc=0x8000000C. Same with taken=0 -> 0x80000014.
- JALR misaligned: rs1=0x80001003, instr imm=0, type 2 at pc=0x80000020 -> io_pc_next=0x80001002, io_fault=1 for one cycle, io_fault_pc=0x80000020, cause=2. trap_vector=0x80000100 -> io_pc=0x80000100, retired unchanged.
- Unknown plus counter wrap: CNT_WIDTH=4, 15 SEQ then type 7 -> io_retired=15, cause=1, PC redirected to io_trap_vector. One more SEQ -> io_retired=0.
- Halt then reset: type 4 accepted -> io_halted=1, PC frozen through 5 cycles of valid JAL. Assert reset for 1 cycle -> io_pc=0x80000000, io_halted=0.
